// File: rtl/beep_pkg.sv
// Shared definitions for the beep melody player: note codes, FSM states and
// the per-note half-period table derived from the system clock frequency.
package beep_pkg;

    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned TONE_W    = 17;
    localparam int unsigned NUM_NOTES = 16;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd13;
    localparam logic [NOTE_W-1:0] NOTE_D5   = 4'd14;
    localparam logic [NOTE_W-1:0] NOTE_E5   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic [NUM_NOTES-1:0][TONE_W-1:0] half_tbl_t;

    // Equal-temperament pitches rounded to whole hertz
    function automatic int unsigned note_freq_hz(input logic [NOTE_W-1:0] code);
        case (code)
            NOTE_C4:  return 262;
            NOTE_CS4: return 277;
            NOTE_D4:  return 294;
            NOTE_DS4: return 311;
            NOTE_E4:  return 330;
            NOTE_F4:  return 349;
            NOTE_FS4: return 370;
            NOTE_G4:  return 392;
            NOTE_GS4: return 415;
            NOTE_A4:  return 440;
            NOTE_AS4: return 466;
            NOTE_B4:  return 494;
            NOTE_C5:  return 523;
            NOTE_D5:  return 587;
            NOTE_E5:  return 659;
            default:  return 0;
        endcase
    endfunction

    // round(clk_hz / (2*f)) per note; the rest entry stays zero
    function automatic half_tbl_t half_table(input int unsigned clk_hz);
        half_tbl_t   tbl;
        int unsigned f;
        tbl = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            f = note_freq_hz(NOTE_W'(i));
            if (f != 0) begin
                tbl[i] = TONE_W'((clk_hz + f) / (2 * f));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/beep_song_rom.sv
// Fixed melody storage: four songs of sixteen 4-bit note codes, beat 0 in the
// least-significant nibble of each song word.
module beep_song_rom
    import beep_pkg::*;
(
    input  logic [1:0]        song,
    input  logic [3:0]        idx,
    output logic [NOTE_W-1:0] note_c
);

    localparam logic [63:0] SONG0 = 64'hDF0D_CA08_A0C8_DA0A;
    localparam logic [63:0] SONG1 = 64'h1357_8A0C_1357_8AC0;
    localparam logic [63:0] SONG2 = 64'h0E0E_DDCC_AA88_5310;
    localparam logic [63:0] SONG3 = 64'h1111_0000_3355_88AA;

    logic [63:0] song_bits_c;

    always_comb begin
        song_bits_c = SONG0;
        case (song)
            2'd0:    song_bits_c = SONG0;
            2'd1:    song_bits_c = SONG1;
            2'd2:    song_bits_c = SONG2;
            default: song_bits_c = SONG3;
        endcase
        note_c = song_bits_c[{idx, 2'b00} +: NOTE_W];
    end

endmodule

// File: rtl/beep_melody_player.sv
// Beat-driven melody player: steps a note ROM on each rhythm tick and drives
// a square wave on beep. Define BEEP_ARTIC_EN for a silent gap after each beat.
module beep_melody_player
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
`ifdef BEEP_ARTIC_EN
    parameter int unsigned ARTIC_CYC = 1_000_000,
`endif
    parameter int unsigned SONG_LEN  = 16
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       rhythm_tick,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] song_sel,
    output logic       beep,
    output logic       busy,
    output logic       done,
    output logic [3:0] note_idx
);

    localparam half_tbl_t HALF_TBL = half_table(CLK_HZ);

    state_e              state_q, state_d;
    logic [3:0]          note_idx_q, note_idx_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [1:0]          song_q, song_d;
    logic                beep_q, beep_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NOTE_W-1:0]   note_c;
    logic [TONE_W-1:0]   half_c;
    logic                last_beat_c;

`ifdef BEEP_ARTIC_EN
    localparam int unsigned GAP_W = (ARTIC_CYC > 1) ? $clog2(ARTIC_CYC) : 1;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
`endif

    beep_song_rom u_rom (
        .song   (song_q),
        .idx    (note_idx_q),
        .note_c (note_c)
    );

    assign half_c      = HALF_TBL[note_c];
    assign last_beat_c = (note_idx_q == 4'(SONG_LEN - 1));

    // Next-state, tone generation and beat stepping
    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        tone_cnt_d = tone_cnt_q;
        song_d     = song_q;
        beep_d     = beep_q;
`ifdef BEEP_ARTIC_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                beep_d     = 1'b0;
                tone_cnt_d = '0;
                if (start) begin
                    state_d    = ST_PLAY;
                    song_d     = song_sel;
                    note_idx_d = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    beep_d     = 1'b0;
                    tone_cnt_d = '0;
                end else if (rhythm_tick) begin
                    beep_d     = 1'b0;
                    tone_cnt_d = '0;
                    if (last_beat_c) begin
                        state_d = ST_DONE;
                    end else begin
                        note_idx_d = note_idx_q + 4'd1;
`ifdef BEEP_ARTIC_EN
                        state_d    = ST_GAP;
                        gap_cnt_d  = '0;
`endif
                    end
                end else if (note_c == NOTE_REST) begin
                    beep_d     = 1'b0;
                    tone_cnt_d = '0;
                end else if (tone_cnt_q == half_c - TONE_W'(1)) begin
                    tone_cnt_d = '0;
                    beep_d     = ~beep_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + TONE_W'(1);
                end
            end
`ifdef BEEP_ARTIC_EN
            // Silent articulation window; a tick here still advances the beat
            ST_GAP: begin
                beep_d     = 1'b0;
                tone_cnt_d = '0;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (rhythm_tick) begin
                    if (last_beat_c) begin
                        state_d = ST_DONE;
                    end else begin
                        note_idx_d = note_idx_q + 4'd1;
                        gap_cnt_d  = '0;
                    end
                end else if (gap_cnt_q == GAP_W'(ARTIC_CYC - 1)) begin
                    state_d = ST_PLAY;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d    = ST_IDLE;
                beep_d     = 1'b0;
                tone_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                beep_d     = 1'b0;
                tone_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == ST_PLAY) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            note_idx_q <= '0;
            tone_cnt_q <= '0;
            song_q     <= '0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BEEP_ARTIC_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            tone_cnt_q <= tone_cnt_d;
            song_q     <= song_d;
            beep_q     <= beep_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BEEP_ARTIC_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign beep     = beep_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule
